pulse_width_detector: RTL

- Multi-channel successor to the single-bit one-cycle-pulse (010) detector. Each of N_CH independent channels detects complete pulses of a selectable polarity and measures each pulse's width. A pulse is classified in range when MIN_W <= width <= MAX_W.
- Used as a front-end qualifier for glitch filtering and strobe validation on asynchronous-origin control lines, already synchronised upstream.
- Defaults (MIN_W = MAX_W = 1, pol = 1) reproduce exact 010 detection per channel, registered.

---
 rtl/pulse_width_detector.sv | 97 +++++++++
 1 files changed

// File: rtl/pulse_width_detector.sv
// Multi-channel pulse detector: finds complete pulses of a selectable polarity
// on each channel, measures their width and classifies them against [MIN_W, MAX_W].
module pulse_width_detector #(
  parameter  int N_CH  = 4,
  parameter  int MIN_W = 1,
  parameter  int MAX_W = 1,
  localparam int CNT_W = $clog2(MAX_W + 2)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic [N_CH-1:0]       a,
  input  logic [N_CH-1:0]       pol,
  output logic [N_CH-1:0]       rise,
  output logic [N_CH-1:0]       fall,
  output logic [N_CH-1:0]       pulse_ok,
  output logic [N_CH-1:0]       pulse_bad,
  output logic [N_CH-1:0]       stuck,
  output logic [N_CH*CNT_W-1:0] width
);

  localparam logic [CNT_W-1:0] SAT  = CNT_W'(MAX_W + 1);
  localparam logic [CNT_W-1:0] LO   = CNT_W'(MIN_W);
  localparam logic [CNT_W-1:0] HI   = CNT_W'(MAX_W);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] ZERO = CNT_W'(1'b0);

  // Active level is a XNOR pol: high pulses when pol=1, low pulses when pol=0.
  logic [N_CH-1:0] w_act;
  assign w_act = ~(a ^ pol);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic             r_armed;
    logic             r_pol;
    logic             r_rise;
    logic             r_fall;
    logic             r_ok;
    logic             r_bad;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_width;
    logic             w_in_range;

    assign w_in_range = (r_cnt >= LO) && (r_cnt <= HI);

    // Per-channel arm / count / report sequencing; strobes default low each cycle.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_armed <= 1'b0;
        r_pol   <= 1'b0;
        r_cnt   <= ZERO;
        r_width <= ZERO;
        r_rise  <= 1'b0;
        r_fall  <= 1'b0;
        r_ok    <= 1'b0;
        r_bad   <= 1'b0;
      end else begin
        r_rise <= 1'b0;
        r_fall <= 1'b0;
        r_ok   <= 1'b0;
        r_bad  <= 1'b0;
        if (clr) begin
          r_armed <= 1'b0;
          r_pol   <= pol[i];
          r_cnt   <= ZERO;
          r_width <= ZERO;
        end else if (pol[i] != r_pol) begin
          r_pol   <= pol[i];
          r_armed <= 1'b0;
          r_cnt   <= ZERO;
        end else if (!r_armed) begin
          // Arming needs an idle sample, so a line already active is never reported.
          r_armed <= ~w_act[i];
          r_cnt   <= ZERO;
        end else if (w_act[i]) begin
          r_cnt  <= (r_cnt == SAT) ? r_cnt : r_cnt + ONE;
          r_rise <= (r_cnt == ZERO);
        end else if (r_cnt != ZERO) begin
          r_fall  <= 1'b1;
          r_width <= r_cnt;
          r_ok    <= w_in_range;
          r_bad   <= ~w_in_range;
          r_cnt   <= ZERO;
        end else begin
          r_cnt <= ZERO;
        end
      end
    end

    assign rise[i]                    = r_rise;
    assign fall[i]                    = r_fall;
    assign pulse_ok[i]                = r_ok;
    assign pulse_bad[i]               = r_bad;
    assign stuck[i]                   = (r_cnt == SAT);
    assign width[i*CNT_W +: CNT_W]    = r_width;
  end

endmodule
